valu_result_stage: RTL and testbench

//  Registered result stage directly downstream of the packed 4x8-bit vector ALU.
//  - Captures each ALU result with a valid/ready handshake.
//  - Optionally saturates VSUM/VSUB lanes.
//  - Accumulates VDP partial sums across multi-beat chains.
//  - Buffers up to 2 results for vector register writeback, which may stall.

---
 rtl/valu_pkg.sv | 39 +++
 rtl/valu_skid_fifo.sv | 65 ++++++
 rtl/valu_result_stage.sv | 131 +++++++++++++
 tb/tb_valu_result_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Shared types and constants for the vector ALU result stage: opcodes, lane
// geometry, chain states and the buffered result entry.
package valu_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;
    localparam int RD_W      = 5;

    localparam logic [2:0] OP_VSUM = 3'b010;
    localparam logic [2:0] OP_VSUB = 3'b110;
    localparam logic [2:0] OP_VDP  = 3'b001;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } chain_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [RD_W-1:0]      rd;
        logic [NUM_LANES-1:0] sat;
        logic                 trunc;
    } entry_t;

    // Signed overflow of one lane, judged from the operand sign bits and the result sign.
    function automatic logic lane_ovf(input logic [2:0] op, input logic r_msb,
                                      input logic a_msb, input logic b_msb);
        logic ovf;
        ovf = 1'b0;
        if (op == OP_VSUM) begin
            ovf = (a_msb == b_msb) && (r_msb != a_msb);
        end else if (op == OP_VSUB) begin
            ovf = (a_msb != b_msb) && (r_msb != a_msb);
        end
        return ovf;
    endfunction

endpackage

// File: rtl/valu_skid_fifo.sv
// Two-entry FIFO of result entries between the result stage and writeback.
// Head reads as zero while empty so the downstream outputs stay quiet.
module valu_skid_fifo
    import valu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   push_i,
    input  entry_t push_entry_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output logic   valid_o,
    output entry_t head_o
);

    entry_t     mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign valid_o = ~empty_o;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/valu_result_stage.sv
// Result stage after the 4x8-bit vector ALU: lane saturation, VDP chain accumulation
// and a 2-entry writeback buffer. Define VALU_SAT_EN to clamp overflowing VSUM/VSUB lanes.
module valu_result_stage
    import valu_pkg::*;
#(
    parameter int MAX_CHAIN = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           valu_ctrl_i,
    input  logic [DATA_W-1:0]    v_i,
    input  logic [NUM_LANES-1:0] a_msb_i,
    input  logic [NUM_LANES-1:0] b_msb_i,
    input  logic [RD_W-1:0]      rd_i,
    input  logic                 acc_first_i,
    input  logic                 acc_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    out_data_o,
    output logic [RD_W-1:0]      out_rd_o,
    output logic [NUM_LANES-1:0] out_sat_o,
    output logic                 out_trunc_o,
    output logic                 err_o
);

`ifdef VALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int LEN_W = $clog2(MAX_CHAIN + 1);

    chain_state_e         chain_state_q, chain_state_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 err_q, err_d;

    logic                 accept, vdp_beat, restart, chain_close;
    logic [DATA_W-1:0]    sum;
    logic [LEN_W-1:0]     sum_len;
    logic [DATA_W-1:0]    lane_data;
    logic [NUM_LANES-1:0] lane_sat;
    logic                 push, fifo_full, fifo_empty, fifo_valid;
    entry_t               push_entry, head;

    assign accept   = in_valid_i & in_ready_o;
    assign vdp_beat = accept & (valu_ctrl_i == OP_VDP);

    // A first beat, or any beat with no open chain, starts the accumulator over.
    assign restart     = (chain_state_q == IDLE) | acc_first_i;
    assign sum         = restart ? v_i : acc_q + v_i;
    assign sum_len     = restart ? LEN_W'(1) : len_q + LEN_W'(1);
    assign chain_close = acc_last_i | (sum_len == LEN_W'(MAX_CHAIN));

    always_comb begin
        lane_data = v_i;
        lane_sat  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (SAT_EN && lane_ovf(valu_ctrl_i, v_i[k*LANE_W + LANE_W-1],
                                   a_msb_i[k], b_msb_i[k])) begin
                lane_data[k*LANE_W +: LANE_W] = a_msb_i[k] ? 8'h80 : 8'h7F;
                lane_sat[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_state_q <= IDLE;
            acc_q         <= '0;
            len_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            chain_state_q <= chain_state_d;
            acc_q         <= acc_d;
            len_q         <= len_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        chain_state_d = chain_state_q;
        if (vdp_beat) begin
            chain_state_d = chain_close ? IDLE : ACCUM;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        len_d      = len_q;
        err_d      = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        if (vdp_beat) begin
            acc_d = sum;
            len_d = chain_close ? '0 : sum_len;
            err_d = (chain_state_q == IDLE) & ~acc_first_i;
            if (chain_close) begin
                push       = 1'b1;
                push_entry = '{data: sum, rd: rd_i, sat: '0, trunc: ~acc_last_i};
            end
        end else if (accept) begin
            push       = 1'b1;
            push_entry = '{data: lane_data, rd: rd_i, sat: lane_sat, trunc: 1'b0};
        end
    end

    valu_skid_fifo u_fifo (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (out_ready_i),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .valid_o      (fifo_valid),
        .head_o       (head)
    );

    assign in_ready_o  = ~fifo_full;
    assign out_valid_o = fifo_valid & ~fifo_empty;
    assign out_data_o  = head.data;
    assign out_rd_o    = head.rd;
    assign out_sat_o   = head.sat;
    assign out_trunc_o = head.trunc;
    assign err_o       = err_q;

endmodule

// File: tb/tb_valu_result_stage.sv
// Bench for valu_result_stage (short chain limit of 4): directed vector table,
// multi-cycle corner sequences and random beats against a queue-based reference model.
module tb_valu_result_stage;

    localparam int MAXC = 4;
    localparam logic [2:0] VSUM = 3'b010;
    localparam logic [2:0] VSUB = 3'b110;
    localparam logic [2:0] VDP  = 3'b001;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i, in_ready_o;
    logic [2:0]  valu_ctrl_i;
    logic [31:0] v_i;
    logic [3:0]  a_msb_i, b_msb_i;
    logic [4:0]  rd_i;
    logic        acc_first_i, acc_last_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_data_o;
    logic [4:0]  out_rd_o;
    logic [3:0]  out_sat_o;
    logic        out_trunc_o, err_o;

    valu_result_stage #(.MAX_CHAIN(MAXC)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .valu_ctrl_i (valu_ctrl_i),
        .v_i         (v_i),
        .a_msb_i     (a_msb_i),
        .b_msb_i     (b_msb_i),
        .rd_i        (rd_i),
        .acc_first_i (acc_first_i),
        .acc_last_i  (acc_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_rd_o    (out_rd_o),
        .out_sat_o   (out_sat_o),
        .out_trunc_o (out_trunc_o),
        .err_o       (err_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [41:0] exp_q[$];
    logic        m_open;
    logic [31:0] m_acc;
    int          m_len;
    logic        err_exp;

    function automatic logic [41:0] alu_entry(input logic [2:0] op, input logic [31:0] v,
                                              input logic [3:0] am, input logic [3:0] bm,
                                              input logic [4:0] rd);
        logic [31:0] d;
        logic [3:0]  s;
        logic [7:0]  r;
        logic        ovf;
        d = v;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            r   = v[8*k +: 8];
            ovf = 1'b0;
            if (op == VSUM) ovf = (am[k] == bm[k]) && (r[7] != am[k]);
            if (op == VSUB) ovf = (am[k] != bm[k]) && (r[7] != am[k]);
`ifdef VALU_SAT_EN
            if (ovf) begin
                d[8*k +: 8] = am[k] ? 8'h80 : 8'h7F;
                s[k] = 1'b1;
            end
`else
            if (ovf) s[k] = 1'b0;
`endif
        end
        return {d, rd, s, 1'b0};
    endfunction

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            exp_q.delete();
            m_open  <= 1'b0;
            m_acc   <= '0;
            m_len   <= 0;
            err_exp <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            if (valu_ctrl_i == VDP) begin
                logic [31:0] na;
                int          nl;
                err_exp <= !m_open && !acc_first_i;
                if (!m_open || acc_first_i) begin
                    na = v_i;
                    nl = 1;
                end else begin
                    na = m_acc + v_i;
                    nl = m_len + 1;
                end
                m_acc <= na;
                m_len <= nl;
                if (acc_last_i) begin
                    exp_q.push_back({na, rd_i, 4'b0000, 1'b0});
                    m_open <= 1'b0;
                end else if (nl == MAXC) begin
                    exp_q.push_back({na, rd_i, 4'b0000, 1'b1});
                    m_open <= 1'b0;
                end else begin
                    m_open <= 1'b1;
                end
            end else begin
                exp_q.push_back(alu_entry(valu_ctrl_i, v_i, a_msb_i, b_msb_i, rd_i));
                err_exp <= 1'b0;
            end
        end else begin
            err_exp <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            check("err_o", {63'd0, err_o}, {63'd0, err_exp});
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {22'd0, out_data_o, out_rd_o, out_sat_o, out_trunc_o}, 64'h0);
                    n_fail += (out_data_o == 32'h0 && out_rd_o == 5'h0) ? 1 : 0;
                end else begin
                    check("out_entry", {22'd0, out_data_o, out_rd_o, out_sat_o, out_trunc_o},
                          {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [2:0] op, input logic [31:0] v, input logic [3:0] am,
                              input logic [3:0] bm, input logic [4:0] rd, input logic first,
                              input logic last, input bit rand_rdy);
        int waited = 0;
        valu_ctrl_i = op;
        v_i         = v;
        a_msb_i     = am;
        b_msb_i     = bm;
        rd_i        = rd;
        acc_first_i = first;
        acc_last_i  = last;
        in_valid_i  = 1'b1;
        while (!in_ready_o && waited < 200) begin
            @(posedge clk_i);
            #1;
            waited++;
            if (rand_rdy) out_ready_i = ($urandom_range(0, 1) == 1);
        end
        if (!in_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready_o stayed 0 for %0d cycles", waited);
        end else begin
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_out_valid"}, {63'd0, out_valid_o}, 64'd0);
        check({tag, "_out_data"}, {32'd0, out_data_o}, 64'd0);
        check({tag, "_out_rd_sat_trunc"}, {54'd0, out_rd_o, out_sat_o, out_trunc_o}, 64'd0);
        check({tag, "_err"}, {63'd0, err_o}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready_o}, 64'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] v;
        logic [3:0]  am;
        logic [3:0]  bm;
        logic [4:0]  rd;
        logic        first;
        logic        last;
        logic [31:0] exp_data;
        logic [3:0]  exp_sat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        rst_n_i     = 1'b0;
        in_valid_i  = 1'b0;
        valu_ctrl_i = '0;
        v_i         = '0;
        a_msb_i     = '0;
        b_msb_i     = '0;
        rd_i        = '0;
        acc_first_i = 1'b0;
        acc_last_i  = 1'b0;
        out_ready_i = 1'b1;

`ifdef VALU_SAT_EN
        vecs[0] = '{VSUM, 32'h00000080, 4'h0, 4'h0, 5'd1, 1'b0, 1'b0, 32'h0000007F, 4'b0001};
        vecs[1] = '{VSUB, 32'h7F000000, 4'h8, 4'h0, 5'd2, 1'b0, 1'b0, 32'h80000000, 4'b1000};
        vecs[4] = '{VSUM, 32'h7F7F7F7F, 4'hF, 4'hF, 5'd5, 1'b0, 1'b0, 32'h80808080, 4'b1111};
        vecs[6] = '{VSUB, 32'h00FF0080, 4'h1, 4'h4, 5'd8, 1'b0, 1'b0, 32'h007F0080, 4'b0100};
`else
        vecs[0] = '{VSUM, 32'h00000080, 4'h0, 4'h0, 5'd1, 1'b0, 1'b0, 32'h00000080, 4'b0000};
        vecs[1] = '{VSUB, 32'h7F000000, 4'h8, 4'h0, 5'd2, 1'b0, 1'b0, 32'h7F000000, 4'b0000};
        vecs[4] = '{VSUM, 32'h7F7F7F7F, 4'hF, 4'hF, 5'd5, 1'b0, 1'b0, 32'h7F7F7F7F, 4'b0000};
        vecs[6] = '{VSUB, 32'h00FF0080, 4'h1, 4'h4, 5'd8, 1'b0, 1'b0, 32'h00FF0080, 4'b0000};
`endif
        vecs[2] = '{3'b000, 32'hDEADBEEF, 4'hF, 4'h0, 5'd3, 1'b0, 1'b0, 32'hDEADBEEF, 4'b0000};
        vecs[3] = '{VSUM, 32'h80808080, 4'hF, 4'hF, 5'd4, 1'b0, 1'b0, 32'h80808080, 4'b0000};
        vecs[5] = '{VDP, 32'h12345678, 4'h0, 4'h0, 5'd6, 1'b1, 1'b1, 32'h12345678, 4'b0000};

        // ---------------- reset ----------------
        tick(3);
        check_quiet_outputs("in_reset");
        rst_n_i = 1'b1;
        tick(2);
        check_quiet_outputs("after_reset");

        // ---------------- vector table ----------------
        for (int i = 0; i < 7; i++) begin
            drive_beat(vecs[i].op, vecs[i].v, vecs[i].am, vecs[i].bm, vecs[i].rd,
                       vecs[i].first, vecs[i].last, 1'b0);
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid_o}, 64'd1);
            check($sformatf("vec%0d_data", i), {32'd0, out_data_o}, {32'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_sat", i), {60'd0, out_sat_o}, {60'd0, vecs[i].exp_sat});
            check($sformatf("vec%0d_rd_trunc", i), {58'd0, out_rd_o, out_trunc_o},
                  {58'd0, vecs[i].rd, 1'b0});
        end
        tick(2);

        // ---------------- three-beat VDP chain ----------------
        drive_beat(VDP, 32'd10, 4'h0, 4'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        check("chain_first_no_out", {63'd0, out_valid_o}, 64'd0);
        drive_beat(VDP, 32'hFFFFFFFD, 4'h0, 4'h0, 5'd2, 1'b0, 1'b0, 1'b0);
        check("chain_mid_no_out", {63'd0, out_valid_o}, 64'd0);
        drive_beat(VDP, 32'd5, 4'h0, 4'h0, 5'd7, 1'b0, 1'b1, 1'b0);
        check("chain_last_valid", {63'd0, out_valid_o}, 64'd1);
        check("chain_last_data_rd", {27'd0, out_data_o, out_rd_o}, {27'd0, 32'h0000000C, 5'd7});
        tick(1);
        check("chain_single_output", {63'd0, out_valid_o}, 64'd0);

        // ---------------- back-pressure: three beats into two entries ----------------
        out_ready_i = 1'b0;
        drive_beat(VSUM, 32'h00000001, 4'h0, 4'h0, 5'd11, 1'b0, 1'b0, 1'b0);
        check("bp_ready_after_1", {63'd0, in_ready_o}, 64'd1);
        drive_beat(VSUM, 32'h00000002, 4'h0, 4'h0, 5'd12, 1'b0, 1'b0, 1'b0);
        check("bp_ready_after_2", {63'd0, in_ready_o}, 64'd0);
        valu_ctrl_i = VSUM;
        v_i         = 32'h00000003;
        a_msb_i     = 4'h0;
        b_msb_i     = 4'h0;
        rd_i        = 5'd13;
        acc_first_i = 1'b0;
        acc_last_i  = 1'b0;
        in_valid_i  = 1'b1;
        tick(3);
        check("bp_third_held", {63'd0, in_ready_o}, 64'd0);
        check("bp_head_is_first", {32'd0, out_data_o}, 64'h1);
        out_ready_i = 1'b1;
        tick(1);
        check("bp_ready_after_pop", {63'd0, in_ready_o}, 64'd1);
        tick(1);
        in_valid_i = 1'b0;
        tick(4);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // ---------------- reset in the middle of a chain ----------------
        drive_beat(VDP, 32'h00000100, 4'h0, 4'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        rst_n_i = 1'b0;
        tick(1);
        check_quiet_outputs("midchain_reset");
        tick(1);
        rst_n_i = 1'b1;
        tick(1);
        check_quiet_outputs("post_midchain_reset");
        drive_beat(VDP, 32'h00000055, 4'h0, 4'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("orphan_err_pulse", {63'd0, err_o}, 64'd1);
        tick(1);
        check("orphan_err_once", {63'd0, err_o}, 64'd0);
        drive_beat(VDP, 32'h00000001, 4'h0, 4'h0, 5'd9, 1'b0, 1'b1, 1'b0);
        check("orphan_acc_restart", {32'd0, out_data_o}, 64'h56);
        tick(2);

        // ---------------- chain forced to flush at the length limit ----------------
        drive_beat(VDP, 32'd1, 4'h0, 4'h0, 5'd20, 1'b1, 1'b0, 1'b0);
        drive_beat(VDP, 32'd1, 4'h0, 4'h0, 5'd21, 1'b0, 1'b0, 1'b0);
        drive_beat(VDP, 32'd1, 4'h0, 4'h0, 5'd22, 1'b0, 1'b0, 1'b0);
        check("trunc_no_early_out", {63'd0, out_valid_o}, 64'd0);
        drive_beat(VDP, 32'd1, 4'h0, 4'h0, 5'd23, 1'b0, 1'b0, 1'b0);
        check("trunc_out", {26'd0, out_valid_o, out_data_o, out_trunc_o},
              {26'd0, 1'b1, 32'd4, 1'b1});
        check("trunc_rd", {59'd0, out_rd_o}, 64'd23);
        drive_beat(VDP, 32'd9, 4'h0, 4'h0, 5'd24, 1'b0, 1'b1, 1'b0);
        check("trunc_back_to_idle_err", {63'd0, err_o}, 64'd1);
        check("trunc_back_to_idle_data", {32'd0, out_data_o}, 64'd9);
        tick(2);

        // ---------------- random beats ----------------
        for (int i = 0; i < 400; i++) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                tick(1);
            end else begin
                int          sel;
                logic [2:0]  op;
                sel = $urandom_range(0, 9);
                if (sel < 4)      op = VDP;
                else if (sel < 6) op = VSUM;
                else if (sel < 8) op = VSUB;
                else              op = 3'($urandom_range(0, 7));
                drive_beat(op, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 3) == 0), 1'b1);
            end
        end

        // ---------------- drain ----------------
        out_ready_i = 1'b1;
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick(1);
        tick(2);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_out_valid", {63'd0, out_valid_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
